im_feeder: RTL

Upstream sequencer for the HDC classifier datapath. It accepts a stream of quantized feature levels, looks up each feature's level hypervector and position hypervector in two loadable item memories, and drives the encoder inputs `im_value`, `im_pos`, `smp_en`, `smp_clr`, `set_clr`, `state` and `label` with correct per-sample and per-set framing. One `start` runs either a training set of `SET_SIZE` samples or a single prediction sample.

---
 rtl/hdc_pkg.sv | 39 +++
 rtl/item_mem.sv | 36 +++
 rtl/im_feeder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hdc_pkg.sv
// Shared types and width helpers for the HDC classifier front end.
`ifndef DIM
`define DIM 256
`endif
`ifndef SMP_SIZE
`define SMP_SIZE 16
`endif
`ifndef SET_SIZE
`define SET_SIZE 8
`endif
`ifndef CLS_DW
`define CLS_DW 4
`endif

package hdc_pkg;

   typedef enum logic {
      TRAIN   = 1'b0,
      PREDICT = 1'b1
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } feeder_state_e;

   // Bits needed to index n distinct values, never less than one.
   function automatic int cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int LVL_DW = cw(16);
   localparam int SMP_DW = cw(`SMP_SIZE + 1);
   localparam int SET_DW = cw(`SET_SIZE + 1);

endpackage

// File: rtl/item_mem.sv
// Register-array item memory: one synchronous write port, one registered read port.
module item_mem #(
   parameter int DEPTH = 16,
   parameter int DIM   = 8,
   parameter int AW    = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  logic [DIM-1:0] wdata,
   input  logic           re,
   input  logic [AW-1:0]  raddr,
   output logic [DIM-1:0] rdata
);

   logic [DIM-1:0] mem_q [DEPTH];
   logic [DIM-1:0] rdata_q, rdata_d;

   // Contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_comb begin
      rdata_d = re ? mem_q[raddr] : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/im_feeder.sv
// Feature sequencer: looks up level/position HVs and frames samples and sets
// for the HDC encoder.
//
//   state    | meaning
//   IDLE     | waiting for start, config writes allowed
//   CLR      | one-cycle sample clear (plus set clear on first TRAIN sample)
//   FEED     | accepting SMP_SIZE features
//   DRAIN    | let the last lookup land, then DRAIN_CYC idle cycles
//   FIN      | one-cycle done pulse
module im_feeder
   import hdc_pkg::*;
#(
   parameter  int DIM       = `DIM,
   parameter  int LVL_NUM   = 16,
   parameter  int SMP_SIZE  = `SMP_SIZE,
   parameter  int SET_SIZE  = `SET_SIZE,
   parameter  int CLS_DW    = `CLS_DW,
   parameter  int DRAIN_CYC = 4,
   localparam int CFG_AW    = cw((LVL_NUM > SMP_SIZE) ? LVL_NUM : SMP_SIZE),
   localparam int LVL_AW    = cw(LVL_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [DIM-1:0]    cfg_wdata,
   output logic              cfg_err,
   input  logic              start,
   input  logic              mode,
   input  logic [CLS_DW-1:0] label_in,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [LVL_AW-1:0] s_level,
   output logic [DIM-1:0]    im_value,
   output logic [DIM-1:0]    im_pos,
   output logic              smp_en,
   output logic              smp_clr,
   output logic              set_clr,
   output logic              state,
   output logic [CLS_DW-1:0] label,
   output logic              busy,
   output logic              done
);

   localparam int FEAT_W = cw(SMP_SIZE + 1);
   localparam int SMPC_W = cw(SET_SIZE + 1);
   localparam int DRN_W  = cw(DRAIN_CYC + 1);

   feeder_state_e     st_q, st_d;
   mode_e             mode_q, mode_d;
   logic [CLS_DW-1:0] label_q, label_d;
   logic [FEAT_W-1:0] feat_cnt_q, feat_cnt_d;
   logic [SMPC_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic              s_ready_q, s_ready_d;
   logic              smp_en_q, smp_en_d;
   logic              smp_clr_q, smp_clr_d;
   logic              set_clr_q, set_clr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cfg_err_q, cfg_err_d;

   logic              hs, idle, cfg_oor, lvl_we, pos_we;
   logic [LVL_AW-1:0] lvl_idx;

   assign hs   = s_valid && s_ready_q;
   assign idle = (st_q == ST_IDLE);

   always_comb begin
      cfg_oor = cfg_sel ? (int'(cfg_addr) >= SMP_SIZE) : (int'(cfg_addr) >= LVL_NUM);
      lvl_idx = (int'(s_level) >= LVL_NUM) ? LVL_AW'(LVL_NUM - 1) : s_level;
   end

   assign lvl_we = cfg_we && idle && !rst && !cfg_sel && !cfg_oor;
   assign pos_we = cfg_we && idle && !rst &&  cfg_sel && !cfg_oor;

   item_mem #(.DEPTH(LVL_NUM), .DIM(DIM), .AW(CFG_AW)) u_lvl_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (lvl_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .re    (hs),
      .raddr (CFG_AW'(lvl_idx)),
      .rdata (im_value)
   );

   item_mem #(.DEPTH(SMP_SIZE), .DIM(DIM), .AW(CFG_AW)) u_pos_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (pos_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .re    (hs),
      .raddr (CFG_AW'(feat_cnt_q)),
      .rdata (im_pos)
   );

   always_comb begin
      st_d       = st_q;
      mode_d     = mode_q;
      label_d    = label_q;
      feat_cnt_d = feat_cnt_q;
      smp_cnt_d  = smp_cnt_q;
      drain_d    = drain_q;
      unique case (st_q)
         ST_IDLE: begin
            if (start) begin
               mode_d    = mode_e'(mode);
               label_d   = label_in;
               smp_cnt_d = '0;
               st_d      = ST_CLR;
            end
         end
         ST_CLR: begin
            feat_cnt_d = '0;
            st_d       = ST_FEED;
         end
         ST_FEED: begin
            if (hs) begin
               feat_cnt_d = feat_cnt_q + FEAT_W'(1);
               if (feat_cnt_q == FEAT_W'(SMP_SIZE - 1)) begin
                  st_d    = ST_DRAIN;
                  drain_d = DRN_W'(DRAIN_CYC);
               end
            end
         end
         // The first DRAIN cycle carries the last lookup; the countdown covers the idle tail.
         ST_DRAIN: begin
            if (drain_q != '0) begin
               drain_d = drain_q - DRN_W'(1);
            end else begin
               smp_cnt_d = smp_cnt_q + SMPC_W'(1);
               if (mode_q == PREDICT || (smp_cnt_q + SMPC_W'(1)) == SMPC_W'(SET_SIZE))
                  st_d = ST_FIN;
               else
                  st_d = ST_CLR;
            end
         end
         ST_FIN:  st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase

      s_ready_d = (st_d == ST_FEED);
      smp_clr_d = (st_d == ST_CLR);
      set_clr_d = (st_d == ST_CLR) && (smp_cnt_d == '0) && (mode_d == TRAIN);
      busy_d    = (st_d != ST_IDLE);
      done_d    = (st_d == ST_FIN);
      smp_en_d  = hs;
      cfg_err_d = cfg_we && (!idle || cfg_oor);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         mode_q     <= TRAIN;
         label_q    <= '0;
         feat_cnt_q <= '0;
         smp_cnt_q  <= '0;
         drain_q    <= '0;
         s_ready_q  <= 1'b0;
         smp_en_q   <= 1'b0;
         smp_clr_q  <= 1'b0;
         set_clr_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         mode_q     <= mode_d;
         label_q    <= label_d;
         feat_cnt_q <= feat_cnt_d;
         smp_cnt_q  <= smp_cnt_d;
         drain_q    <= drain_d;
         s_ready_q  <= s_ready_d;
         smp_en_q   <= smp_en_d;
         smp_clr_q  <= smp_clr_d;
         set_clr_q  <= set_clr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign s_ready = s_ready_q;
   assign smp_en  = smp_en_q;
   assign smp_clr = smp_clr_q;
   assign set_clr = set_clr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cfg_err = cfg_err_q;
   assign state   = mode_q;
   assign label   = label_q;

endmodule
